// File: rtl/pipelined_alu_if.sv
// rtl/pipelined_alu_if.sv - operation/result handshake bundle for the pipelined ALU
interface pipelined_alu_if #(
    parameter int WIDTH = 8
);
    logic             InValid;
    logic             InReady;
    logic [WIDTH-1:0] Operand1;
    logic [WIDTH-1:0] Operand2;
    logic [3:0]       OpCode;
    logic             OutValid;
    logic             OutReady;
    logic [WIDTH-1:0] Result;
    logic             Carry;
    logic             Zero;
    logic             Overflow;
    logic             Error;

    modport master (
        output InValid, Operand1, Operand2, OpCode, OutReady,
        input  InReady, OutValid, Result, Carry, Zero, Overflow, Error
    );

    modport slave (
        input  InValid, Operand1, Operand2, OpCode, OutReady,
        output InReady, OutValid, Result, Carry, Zero, Overflow, Error
    );
endinterface

// File: rtl/pipelined_alu.sv
// rtl/pipelined_alu.sv - combinational ALU feeding a valid-tagged, back-pressured output pipeline
module pipelined_alu #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic           Clock,
    input  logic           Reset_n,
    pipelined_alu_if.slave bus
);
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_NOT  = 4'd5;
    localparam logic [3:0] OP_SHL  = 4'd6;
    localparam logic [3:0] OP_SHR  = 4'd7;
    localparam logic [3:0] OP_ASR  = 4'd8;
    localparam logic [3:0] OP_ROL  = 4'd9;
    localparam logic [3:0] OP_ROR  = 4'd10;
    localparam logic [3:0] OP_SLT  = 4'd11;
    localparam logic [3:0] OP_PASS = 4'd12;

    // WIDTH always fits in WIDTH bits for WIDTH >= 2, so one constant serves
    // both the shift-saturation compare and the rotate modulo.
    localparam logic [WIDTH-1:0] W_VAL = WIDTH[WIDTH-1:0];

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             carry;
        logic             zero;
        logic             overflow;
        logic             error;
    } entry_t;

    entry_t              data_q [STAGES];
    logic [STAGES-1:0]   valid_q;
    logic [STAGES:0]     ld;
    entry_t              comp;

    logic [WIDTH-1:0]    a;
    logic [WIDTH-1:0]    b;
    logic [WIDTH-1:0]    res;
    logic [WIDTH:0]      sum;
    logic [2*WIDTH-1:0]  dbl;
    logic [WIDTH-1:0]    amt;
    logic                cy;
    logic                ov;
    logic                err;

    assign a = bus.Operand1;
    assign b = bus.Operand2;

    // Operation decode and evaluation; result lands in stage 1 on accept.
    always_comb begin
        res = '0;
        sum = '0;
        dbl = '0;
        cy  = 1'b0;
        ov  = 1'b0;
        err = 1'b0;
        amt = b % W_VAL;
        case (bus.OpCode)
            OP_ADD: begin
                sum = {1'b0, a} + {1'b0, b};
                res = sum[WIDTH-1:0];
                cy  = sum[WIDTH];
                ov  = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                // Bit WIDTH of the extended difference is the unsigned borrow.
                sum = {1'b0, a} - {1'b0, b};
                res = sum[WIDTH-1:0];
                cy  = sum[WIDTH];
                ov  = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_XOR:  res = a ^ b;
            OP_NOT:  res = ~a;
            OP_SHL: begin
                if (b >= W_VAL) res = '0;
                else            res = a << b;
            end
            OP_SHR: begin
                if (b >= W_VAL) res = '0;
                else            res = a >> b;
            end
            OP_ASR: begin
                if (b >= W_VAL) res = {WIDTH{a[WIDTH-1]}};
                else            res = $signed(a) >>> b;
            end
            OP_ROL: begin
                dbl = {a, a} << amt;
                res = dbl[2*WIDTH-1:WIDTH];
            end
            OP_ROR: begin
                dbl = {a, a} >> amt;
                res = dbl[WIDTH-1:0];
            end
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_PASS: res = a;
            default: err = 1'b1;
        endcase
        comp.result   = res;
        comp.carry    = cy;
        comp.zero     = (res == '0);
        comp.overflow = ov;
        comp.error    = err;
    end

    // Load enables, evaluated from the output backwards: a stage may load when
    // it is empty or when the stage after it can take its contents.
    always_comb begin
        ld = '0;
        ld[STAGES] = bus.OutReady;
        for (int s = STAGES - 1; s >= 0; s--) begin
            ld[s] = !valid_q[s] || ld[s + 1];
        end
    end

    // Stage registers; stage 0 captures the ALU, later stages shift downstream.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            valid_q <= '0;
            for (int s = 0; s < STAGES; s++) begin
                data_q[s] <= '0;
            end
        end else begin
            if (ld[0]) begin
                valid_q[0] <= bus.InValid;
                data_q[0]  <= comp;
            end
            for (int s = 1; s < STAGES; s++) begin
                if (ld[s]) begin
                    valid_q[s] <= valid_q[s - 1];
                    data_q[s]  <= data_q[s - 1];
                end
            end
        end
    end

    assign bus.InReady  = ld[0] && Reset_n;
    assign bus.OutValid = valid_q[STAGES-1];
    assign bus.Result   = data_q[STAGES-1].result;
    assign bus.Carry    = data_q[STAGES-1].carry;
    assign bus.Zero     = data_q[STAGES-1].zero;
    assign bus.Overflow = data_q[STAGES-1].overflow;
    assign bus.Error    = data_q[STAGES-1].error;
endmodule

// File: tb/tb_pipelined_alu.sv
// tb/tb_pipelined_alu.sv - scoreboard bench for pipelined_alu (WIDTH=8, STAGES=2)
module tb_pipelined_alu;
    logic clk;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    typedef struct {
        logic [7:0] r;
        logic       c;
        logic       z;
        logic       o;
        logic       e;
    } exp_t;

    exp_t sb[$];

    pipelined_alu_if #(.WIDTH(8)) bus ();

    pipelined_alu #(.WIDTH(8), .STAGES(2)) dut (
        .Clock  (clk),
        .Reset_n(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: pops one expectation per output handshake and checks that a
    // stalled output holds steady from one cycle to the next.
    logic [11:0] held;
    logic        held_valid = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            held_valid = 1'b0;
        end else if (bus.OutValid) begin
            if (held_valid)
                chk("stall_stable", {bus.Result, bus.Carry, bus.Zero, bus.Overflow, bus.Error}, held);
            if (bus.OutReady) begin
                held_valid = 1'b0;
                if (sb.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("result",   bus.Result,   e.r);
                    chk("carry",    bus.Carry,    e.c);
                    chk("zero",     bus.Zero,     e.z);
                    chk("overflow", bus.Overflow, e.o);
                    chk("error",    bus.Error,    e.e);
                end
            end else begin
                held       = {bus.Result, bus.Carry, bus.Zero, bus.Overflow, bus.Error};
                held_valid = 1'b1;
            end
        end else begin
            held_valid = 1'b0;
        end
    end

    task automatic send(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] r, input logic c, input logic z,
                        input logic o, input logic e);
        int waited = 0;
        bus.InValid  = 1'b1;
        bus.OpCode   = op;
        bus.Operand1 = a;
        bus.Operand2 = b;
        @(negedge clk);
        while (!bus.InReady && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!bus.InReady) begin
            chk("accept_timeout", 0, 1);
        end else begin
            sb.push_back('{r: r, c: c, z: z, o: o, e: e});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.InValid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            n++;
            @(negedge clk);
        end
        chk("drain_empty", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int t0;
        bus.InValid  = 1'b0;
        bus.OpCode   = 4'h0;
        bus.Operand1 = 8'h00;
        bus.Operand2 = 8'h00;
        bus.OutReady = 1'b1;
        rst_n        = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_outvalid", bus.OutValid, 0);
        chk("rst_inready",  bus.InReady,  0);
        chk("rst_result",   bus.Result,   0);
        chk("rst_flags",    {bus.Carry, bus.Zero, bus.Overflow, bus.Error}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_inready", bus.InReady, 1);

        // First edge after release accepts; result appears two cycles later.
        bus.InValid  = 1'b1;
        bus.OpCode   = 4'd0;
        bus.Operand1 = 8'hFF;
        bus.Operand2 = 8'h01;
        sb.push_back('{r: 8'h00, c: 1'b1, z: 1'b1, o: 1'b0, e: 1'b0});
        @(posedge clk);
        #1;
        idle();
        @(negedge clk);
        chk("latency_c1_outvalid", bus.OutValid, 0);
        @(negedge clk);
        chk("latency_c2_outvalid", bus.OutValid, 1);
        drain();

        // Back-to-back directed vectors, one accept per cycle.
        t0 = cyc;
        send(4'd0,  8'h7F, 8'h01, 8'h80, 0, 0, 1, 0);
        send(4'd1,  8'h80, 8'h01, 8'h7F, 0, 0, 1, 0);
        send(4'd1,  8'h01, 8'h02, 8'hFF, 1, 0, 0, 0);
        send(4'd2,  8'hF0, 8'h3C, 8'h30, 0, 0, 0, 0);
        send(4'd3,  8'hF0, 8'h0F, 8'hFF, 0, 0, 0, 0);
        send(4'd4,  8'hAA, 8'hFF, 8'h55, 0, 0, 0, 0);
        send(4'd5,  8'h0F, 8'h00, 8'hF0, 0, 0, 0, 0);
        send(4'd6,  8'h81, 8'd9,  8'h00, 0, 1, 0, 0);
        send(4'd6,  8'h81, 8'd1,  8'h02, 0, 0, 0, 0);
        send(4'd7,  8'h81, 8'd3,  8'h10, 0, 0, 0, 0);
        send(4'd8,  8'h80, 8'd9,  8'hFF, 0, 0, 0, 0);
        send(4'd8,  8'h80, 8'd2,  8'hE0, 0, 0, 0, 0);
        send(4'd9,  8'h81, 8'd9,  8'h03, 0, 0, 0, 0);
        send(4'd10, 8'h81, 8'd1,  8'hC0, 0, 0, 0, 0);
        send(4'd11, 8'h80, 8'h01, 8'h01, 0, 0, 0, 0);
        send(4'd11, 8'h01, 8'h80, 8'h00, 0, 1, 0, 0);
        send(4'd12, 8'h5A, 8'h00, 8'h5A, 0, 0, 0, 0);
        send(4'hE,  8'h55, 8'hAA, 8'h00, 0, 1, 0, 1);
        send(4'hD,  8'h12, 8'h34, 8'h00, 0, 1, 0, 1);
        send(4'hF,  8'hFF, 8'hFF, 8'h00, 0, 1, 0, 1);
        chk("throughput_cycles", cyc - t0, 20);
        idle();
        drain();

        // Back-pressure: two fill the pipe, the third waits for OutReady.
        bus.OutReady = 1'b0;
        send(4'd0, 8'h10, 8'h20, 8'h30, 0, 0, 0, 0);
        send(4'd4, 8'h0F, 8'h0F, 8'h00, 0, 1, 0, 0);
        fork
            send(4'd12, 8'hA5, 8'h00, 8'hA5, 0, 0, 0, 0);
            begin
                repeat (3) @(negedge clk);
                chk("full_inready",  bus.InReady, 0);
                chk("full_accepted", sb.size(), 2);
                chk("full_outvalid", bus.OutValid, 1);
                @(posedge clk);
                #1;
                bus.OutReady = 1'b1;
            end
        join
        idle();
        drain();

        // Reset with two operations in flight; nothing may emerge afterwards.
        bus.OutReady = 1'b0;
        send(4'd0, 8'h01, 8'h01, 8'h02, 0, 0, 0, 0);
        send(4'd0, 8'h02, 8'h02, 8'h04, 0, 0, 0, 0);
        idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_outvalid", bus.OutValid, 0);
        chk("async_rst_inready",  bus.InReady,  0);
        chk("async_rst_result",   bus.Result,   0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.OutReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_no_output", bus.OutValid, 0);
        end
        @(posedge clk);
        #1;
        send(4'd12, 8'h3C, 8'h00, 8'h3C, 0, 0, 0, 0);
        idle();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
